// File: rtl/rtc_alarm_scheduler.sv
// rtc_alarm_scheduler
//   Alarm scheduler for an RTC seconds-of-day time base. Software programs
//   NSLOT alarm slots over Wishbone. On every enabled seconds tick the block
//   latches time_i and walks the slots one per cycle. A slot whose compare
//   value equals the latched time sets its pending bit. irq_o is the
//   registered OR of pending bits masked by IRQ_EN.
//
//   Optional feature macro: ALARM_REPEAT_EN
//     When it is defined, each slot gets a PERIOD register. A matching slot
//     with a non-zero period re-arms itself at (cmp + period) mod DAY_SECS.
//     When it is undefined, the PERIOD window reads as 0 and ignores writes.
//
//   Register map (byte offsets from BASE_ADR):
//     0x00        CTRL    [0] global enable
//     0x04        STATUS  [NSLOT-1:0] pending (W1C), [31] tick overrun (W1C)
//     0x08        IRQ_EN  [NSLOT-1:0]
//     0x10+4*i    ALARM_i [16:0] compare value, [31] slot enable
//     0x40+4*i    PERIOD_i [16:0] (ALARM_REPEAT_EN only)
module rtc_alarm_scheduler #(
    parameter int          NSLOT    = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0100,
    parameter int          DAY_SECS = 86400
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    input  logic             tick_i,
    input  logic [16:0]      time_i,
    output logic [NSLOT-1:0] pending_o,
    output logic             irq_o
);

    localparam int              IDXW       = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NSLOT - 1);
    localparam logic [16:0]     DAY_MAX    = 17'(DAY_SECS - 1);
    localparam logic [17:0]     DAY_SECS18 = 18'(DAY_SECS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              ack_reg;
    logic [31:0]       dat_reg;
    logic              ctrl_reg;
    logic [NSLOT-1:0]  irq_en_reg;
    logic [NSLOT-1:0]  pending_reg;
    logic              overrun_reg;
    logic              irq_reg;
    logic [0:0]        state_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [16:0]       snap_reg;
    logic [16:0]       alarm_cmp_reg [NSLOT];
    logic [NSLOT-1:0]  alarm_en_reg;
`ifdef ALARM_REPEAT_EN
    logic [16:0]       period_reg    [NSLOT];
    logic [16:0]       period_wr_val [NSLOT];
    logic [16:0]       repeat_next   [NSLOT];
    logic [NSLOT-1:0]  sel_period;
`endif

    logic [0:0]        state_next;
    logic [IDXW-1:0]   idx_next;
    logic              snap_load;
    logic [NSLOT-1:0]  pending_next;
    logic              overrun_next;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic        window_hit;
    logic        access;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  word;
    logic [31:0] byte_mask;
    logic        sel_ctrl;
    logic        sel_status;
    logic        sel_irq_en;
    logic [NSLOT-1:0] sel_alarm;
    logic [31:0] alarm_wr_val [NSLOT];
    logic [31:0] rd_mux;

    logic             scan_active;
    logic [NSLOT-1:0] slot_match;
    logic [NSLOT-1:0] pend_clr;
    logic             ovr_clr;
    logic             status_wr;

    logic [NSLOT-1:0] unused_alarm_bits;
    logic             unused_adr_bits;

    assign window_hit = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // ack_reg gates a new access so ack always drops for a cycle even if
    // the master keeps stb asserted.
    assign access     = wbs_cyc_i & wbs_stb_i & window_hit & ~ack_reg;
    assign wr_en      = access & wbs_we_i;
    assign rd_en      = access & ~wbs_we_i;
    assign word       = wbs_adr_i[7:2];
    assign sel_ctrl   = (word == 6'd0);
    assign sel_status = (word == 6'd1);
    assign sel_irq_en = (word == 6'd2);
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // The scan only compares while the global enable is still set, so a
    // mid-scan disable stops any further pending bits from being raised.
    assign scan_active = (state_reg == ST_SCAN) && ctrl_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end

        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign sel_alarm[gi] = (word == 6'(4 + gi));

            // Registered compare values mean a same-cycle bus write to the
            // slot never affects the compare in flight.
            assign slot_match[gi] = scan_active
                                 && (idx_reg == IDXW'(gi))
                                 && alarm_en_reg[gi]
                                 && (alarm_cmp_reg[gi] == snap_reg)
                                 && (alarm_cmp_reg[gi] <= DAY_MAX);

            assign alarm_wr_val[gi] = ({alarm_en_reg[gi], 14'b0, alarm_cmp_reg[gi]} & ~byte_mask)
                                    | (wbs_dat_i & byte_mask);
            assign unused_alarm_bits[gi] = ^alarm_wr_val[gi][30:17];

`ifdef ALARM_REPEAT_EN
            logic [31:0] period_merged;
            logic [17:0] repeat_sum;
            logic        unused_period_bits;

            assign sel_period[gi] = (word == 6'(16 + gi));
            assign period_merged  = ({15'b0, period_reg[gi]} & ~byte_mask)
                                  | (wbs_dat_i & byte_mask);
            assign unused_period_bits = ^period_merged[31:17];
            // Out-of-range periods saturate so the wrap below stays a
            // single subtract.
            assign period_wr_val[gi] = (period_merged[16:0] > DAY_MAX) ? DAY_MAX
                                                                       : period_merged[16:0];
            // cmp and period are both below DAY_SECS, so one subtract wraps.
            assign repeat_sum = {1'b0, alarm_cmp_reg[gi]} + {1'b0, period_reg[gi]};
            assign repeat_next[gi] = (repeat_sum >= DAY_SECS18) ? 17'(repeat_sum - DAY_SECS18)
                                                                 : repeat_sum[16:0];
`endif
        end
    endgenerate

    // Read data multiplexer; unmapped in-window words read as zero.
    always_comb begin
        rd_mux = '0;
        if (sel_ctrl) begin
            rd_mux[0] = ctrl_reg;
        end
        if (sel_status) begin
            rd_mux[NSLOT-1:0] = pending_reg;
            rd_mux[31]        = overrun_reg;
        end
        if (sel_irq_en) begin
            rd_mux[NSLOT-1:0] = irq_en_reg;
        end
        for (int i = 0; i < NSLOT; i++) begin
            if (sel_alarm[i]) begin
                rd_mux = {alarm_en_reg[i], 14'b0, alarm_cmp_reg[i]};
            end
`ifdef ALARM_REPEAT_EN
            if (sel_period[i]) begin
                rd_mux = {15'b0, period_reg[i]};
            end
`endif
        end
    end

    // Wishbone acknowledge pulse and registered read data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= access;
            if (rd_en) begin
                dat_reg <= rd_mux;
            end
        end
    end

    // Control and interrupt-mask registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_reg   <= 1'b0;
            irq_en_reg <= '0;
        end else begin
            if (wr_en && sel_ctrl && wbs_sel_i[0]) begin
                ctrl_reg <= wbs_dat_i[0];
            end
            if (wr_en && sel_irq_en && wbs_sel_i[0]) begin
                irq_en_reg <= wbs_dat_i[NSLOT-1:0];
            end
        end
    end

    // Alarm slot registers: bus writes take priority over hardware re-arm.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NSLOT; i++) begin
                alarm_cmp_reg[i] <= '0;
            end
            alarm_en_reg <= '0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wr_en && sel_alarm[i]) begin
                    alarm_cmp_reg[i] <= alarm_wr_val[i][16:0];
                    alarm_en_reg[i]  <= alarm_wr_val[i][31];
                end
`ifdef ALARM_REPEAT_EN
                else if (slot_match[i] && (period_reg[i] != '0)) begin
                    alarm_cmp_reg[i] <= repeat_next[i];
                end
`endif
            end
        end
    end

`ifdef ALARM_REPEAT_EN
    // Repeat period registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NSLOT; i++) begin
                period_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wr_en && sel_period[i]) begin
                    period_reg[i] <= period_wr_val[i];
                end
            end
        end
    end
`endif

    // STATUS next value: hardware sets are OR-ed after the W1C so a set wins.
    assign status_wr = wr_en & sel_status;
    assign pend_clr  = status_wr ? (wbs_dat_i[NSLOT-1:0] & byte_mask[NSLOT-1:0]) : '0;
    assign ovr_clr   = status_wr & wbs_dat_i[31] & wbs_sel_i[3];

    always_comb begin
        pending_next = (pending_reg & ~pend_clr) | slot_match;
        overrun_next = (overrun_reg & ~ovr_clr) | ((state_reg == ST_SCAN) && tick_i);
    end

    // STATUS and interrupt registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pending_reg <= '0;
            overrun_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            irq_reg     <= |(pending_reg & irq_en_reg);
        end
    end

    // Scan FSM next-state logic: one slot per cycle after an enabled tick.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        snap_load  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tick_i && ctrl_reg) begin
                    state_next = ST_SCAN;
                    idx_next   = '0;
                    snap_load  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!ctrl_reg || (idx_reg == LAST_IDX)) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Scan FSM state, slot index and time-of-day snapshot.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            snap_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (snap_load) begin
                snap_reg <= time_i;
            end
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign pending_o = pending_reg;
    assign irq_o     = irq_reg;

endmodule

// File: tb/tb_rtc_alarm_scheduler.sv
// Testbench for rtc_alarm_scheduler: table-driven register accesses followed
// by hand-written sequences for scan timing, overrun, W1C races and reset.
module tb_rtc_alarm_scheduler;

    localparam logic [31:0] BASE = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        tick;
    logic [16:0] time_v;
    logic [3:0]  pending;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_alarm_scheduler #(
        .NSLOT(4),
        .BASE_ADR(BASE),
        .DAY_SECS(86400)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_dat_o(dat_r),
        .wbs_ack_o(ack),
        .tick_i   (tick),
        .time_i   (time_v),
        .pending_o(pending),
        .irq_o    (irq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    // One Wishbone access with a bounded wait for ack; checks 1-cycle latency and pulse width.
    task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                break;
            end
        end
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL ack_latency adr=0x%08h: got %0d required 0", a, lat);
        end
        @(posedge clk); #1;
        chk("ack_width", {31'b0, ack}, 32'h0);
        $display("WB %s adr=0x%08h dat=0x%08h sel=%h", w ? "WR" : "RD", a, w ? d : rd, s);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_acc(1'b1, a, d, 4'hF, unused_rd);
    endtask

    task automatic wb_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_acc(1'b0, a, 32'h0, 4'hF, rd);
        chk(name, rd, exp);
    endtask

    // Tick is sampled on the edge after it is driven (the "tick sample edge").
    task automatic do_tick(input logic [16:0] t);
        @(posedge clk); #1;
        tick = 1'b1; time_v = t;
        @(posedge clk); #1;
        tick = 1'b0;
        $display("TICK time=%0d", t);
    endtask

    // Tick, then a bus write whose ack edge coincides with the slot-0 compare edge.
    task automatic tick_then_write(input logic [16:0] t, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        tick = 1'b1; time_v = t;
        @(posedge clk); #1;
        tick = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = 4'hF;
        @(posedge clk); #1;
        chk("sync_write_ack", {31'b0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("TICK+WR time=%0d adr=0x%08h dat=0x%08h", t, a, d);
        wait_cyc(6);
    endtask

    initial begin
        logic [3:0] pat;
        logic       any_ack;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; tick = 1'b0; time_v = '0;

        vecs[0]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'h0};
        vecs[1]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 32'h0};
        vecs[2]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h0};
        vecs[3]  = '{1'b0, BASE + 32'h0C, 32'h0,         4'hF, 32'h0};
        vecs[4]  = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'h0};
        vecs[5]  = '{1'b0, BASE + 32'h14, 32'h0,         4'hF, 32'h0};
        vecs[6]  = '{1'b0, BASE + 32'h18, 32'h0,         4'hF, 32'h0};
        vecs[7]  = '{1'b0, BASE + 32'h1C, 32'h0,         4'hF, 32'h0};
        vecs[8]  = '{1'b0, BASE + 32'h40, 32'h0,         4'hF, 32'h0};
        vecs[9]  = '{1'b1, BASE + 32'h18, 32'h8001_2345, 4'hF, 32'h0};
        vecs[10] = '{1'b0, BASE + 32'h18, 32'h0,         4'hF, 32'h8001_2345};
        vecs[11] = '{1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'h1, 32'h0};
        vecs[12] = '{1'b0, BASE + 32'h18, 32'h0,         4'hF, 32'h8001_23FF};
        vecs[13] = '{1'b1, BASE + 32'h08, 32'h0000_00FF, 4'h1, 32'h0};
        vecs[14] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h0000_000F};
        vecs[15] = '{1'b1, BASE + 32'h08, 32'h0000_0000, 4'h0, 32'h0};
        vecs[16] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h0000_000F};
        vecs[17] = '{1'b1, BASE + 32'h1C, 32'h7FFF_FFFF, 4'hF, 32'h0};
        vecs[18] = '{1'b0, BASE + 32'h1C, 32'h0,         4'hF, 32'h0001_FFFF};
        vecs[19] = '{1'b1, BASE + 32'h08, 32'h0,         4'hF, 32'h0};
        vecs[20] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h0};
        vecs[21] = '{1'b0, BASE + 32'hFC, 32'h0,         4'hF, 32'h0};

        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_pending", {28'b0, pending}, 32'h0);
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_dat", dat_r, 32'h0);

        // Register map vectors: reset values, byte enables, field widths.
        for (int i = 0; i < NV; i++) begin
            logic [31:0] rd;
            wb_acc(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].s, rd);
            if (!vecs[i].wr) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Held strobe: ack must pulse 1,0,1,0.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        pat = '0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            pat = {pat[2:0], ack};
        end
        cyc = 1'b0; stb = 1'b0;
        chk("ack_hold_pattern", {28'b0, pat}, 32'h0000_000A);

        // Out-of-window access: never acked.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0200; dat_w = 32'h1; sel = 4'hF;
        any_ack = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            any_ack |= ack;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("out_of_window_ack", {31'b0, any_ack}, 32'h0);
        wb_read_chk("ctrl_after_oow", BASE + 32'h00, 32'h0);

        // Basic match and interrupt timing.
        wb_write(BASE + 32'h10, 32'h8000_0010);
        wb_write(BASE + 32'h08, 32'h1);
        wb_write(BASE + 32'h00, 32'h1);
        do_tick(17'd15);
        wait_cyc(5);
        wb_read_chk("status_no_match", BASE + 32'h04, 32'h0);
        do_tick(17'd16);
        chk("pend0_not_yet", {28'b0, pending}, 32'h0);
        wait_cyc(1);
        chk("pend0_at_2", {28'b0, pending}, 32'h1);
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        wait_cyc(1);
        chk("irq_at_3", {31'b0, irq}, 32'h1);
        wait_cyc(3);
        wb_write(BASE + 32'h04, 32'h1);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        chk("pend_cleared", {28'b0, pending}, 32'h0);

        // Two slots, slot 1 one cycle later than slot 0.
        wb_write(BASE + 32'h14, 32'h8000_0064);
        wb_write(BASE + 32'h10, 32'h8000_0064);
        do_tick(17'd100);
        wait_cyc(1);
        chk("pend_slot0_only", {28'b0, pending}, 32'h1);
        wait_cyc(1);
        chk("pend_slot01", {28'b0, pending}, 32'h3);
        wait_cyc(4);
        wb_read_chk("status_two", BASE + 32'h04, 32'h3);
        wb_write(BASE + 32'h04, 32'hF);
        wb_write(BASE + 32'h14, 32'h0000_0064);
        do_tick(17'd100);
        wait_cyc(5);
        wb_read_chk("status_slot1_off", BASE + 32'h04, 32'h1);
        chk("irq_slot0", {31'b0, irq}, 32'h1);
        wb_write(BASE + 32'h04, 32'hF);

        // Overrun: back-to-back ticks, the second one (matching) is dropped.
        wb_write(BASE + 32'h10, 32'h8000_00C8);
        @(posedge clk); #1;
        tick = 1'b1; time_v = 17'd50;
        @(posedge clk); #1;
        time_v = 17'd200;
        @(posedge clk); #1;
        tick = 1'b0;
        $display("TICK time=50 then time=200");
        wait_cyc(6);
        wb_read_chk("status_overrun", BASE + 32'h04, 32'h8000_0000);
        wb_write(BASE + 32'h04, 32'h8000_0000);
        wb_read_chk("overrun_cleared", BASE + 32'h04, 32'h0);

        // Tick while disabled: ignored, no overrun.
        wb_write(BASE + 32'h00, 32'h0);
        do_tick(17'd200);
        wait_cyc(5);
        wb_read_chk("status_disabled", BASE + 32'h04, 32'h0);
        wb_write(BASE + 32'h00, 32'h1);

        // Compare values at or beyond DAY_SECS never match.
        wb_write(BASE + 32'h1C, 32'h8001_FFFF);
        do_tick(17'h1FFFF);
        wait_cyc(5);
        wb_write(BASE + 32'h1C, 32'h8001_5180);
        do_tick(17'd86400);
        wait_cyc(5);
        wb_read_chk("status_out_of_range", BASE + 32'h04, 32'h0);
        wb_write(BASE + 32'h1C, 32'h0);

        // Alarm rewritten in its compare cycle: old value still matches.
        wb_write(BASE + 32'h10, 32'h8000_012C);
        tick_then_write(17'd300, BASE + 32'h10, 32'h8000_0001);
        wb_read_chk("status_old_cmp", BASE + 32'h04, 32'h1);
        wb_read_chk("alarm0_new", BASE + 32'h10, 32'h8000_0001);

        // W1C on bit0 in the same cycle the scan sets it: set wins.
        wb_write(BASE + 32'h10, 32'h8000_012C);
        tick_then_write(17'd300, BASE + 32'h04, 32'h1);
        wb_read_chk("status_set_wins", BASE + 32'h04, 32'h1);
        wb_write(BASE + 32'h04, 32'h1);
        wb_read_chk("status_w1c", BASE + 32'h04, 32'h0);

        // Disable mid-scan: slot 0 kept, slot 3 never compared.
        wb_write(BASE + 32'h1C, 32'h8000_012C);
        tick_then_write(17'd300, BASE + 32'h00, 32'h0);
        wb_read_chk("status_abort", BASE + 32'h04, 32'h1);
        wb_write(BASE + 32'h00, 32'h1);
        wb_write(BASE + 32'h04, 32'hF);

        // Reset mid-scan.
        do_tick(17'd300);
        wait_cyc(1);
        chk("pend_before_rst", {28'b0, pending}, 32'h1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        $display("RESET mid-scan");
        chk("rst_pending", {28'b0, pending}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        wb_read_chk("rst_status", BASE + 32'h04, 32'h0);
        wb_read_chk("rst_ctrl", BASE + 32'h00, 32'h0);
        wb_read_chk("rst_alarm0", BASE + 32'h10, 32'h0);
        wb_read_chk("rst_irq_en", BASE + 32'h08, 32'h0);
        wb_write(BASE + 32'h10, 32'h8000_012C);
        wb_write(BASE + 32'h00, 32'h1);
        do_tick(17'd300);
        wait_cyc(1);
        chk("scan_after_rst", {28'b0, pending}, 32'h1);
        wait_cyc(5);
        wb_read_chk("status_after_rst", BASE + 32'h04, 32'h1);
        wb_write(BASE + 32'h04, 32'hF);

`ifdef ALARM_REPEAT_EN
        wb_write(BASE + 32'h40, 32'd10);
        wb_read_chk("period0", BASE + 32'h40, 32'd10);
        wb_write(BASE + 32'h10, 32'h8001_517B);
        do_tick(17'd86395);
        wait_cyc(5);
        wb_read_chk("alarm0_rearm", BASE + 32'h10, 32'h8000_0005);
        wb_read_chk("status_rearm", BASE + 32'h04, 32'h1);
        wb_write(BASE + 32'h40, 32'h0001_FFFF);
        wb_read_chk("period0_clamp", BASE + 32'h40, 32'h0001_517F);
`else
        wb_write(BASE + 32'h40, 32'd10);
        wb_read_chk("period0_absent", BASE + 32'h40, 32'h0);
        wb_write(BASE + 32'h10, 32'h8001_517B);
        do_tick(17'd86395);
        wait_cyc(5);
        wb_read_chk("alarm0_unchanged", BASE + 32'h10, 32'h8001_517B);
        wb_read_chk("status_daily", BASE + 32'h04, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
